// File: rtl/can_id_hopping_tables.sv
`default_nettype none
// ============================================================================
//  Module      : can_id_hopping_tables
//  Description : ID-translation store for CAN ID hopping. It holds a priority
//                table (application ID <-> priority index) and a paged hopping
//                table ((page, priority) <-> physical ID).
//                Send path   : application ID -> priority -> physical ID.
//                Receive path: physical ID -> priority -> application ID.
//                The page is the 4-bit rx/tx message counter.
//  Ports       : clk                   rising-edge clock
//                rest_bit              synchronous reset, active high
//                we                    configuration write strobe
//                id_i                  write data / lookup key
//                send_bit              send lookup request
//                receive_bit           receive lookup request
//                rx_tx_message_counter page select
//                id_o_1                physical ID for transmission
//                id_o_2                application ID of a received message
//                priority_o            priority index of last successful lookup
//                send_hit / recv_hit   last send / receive lookup matched
//                cfg_done              every table entry has been written
//  Revision    : 1.0 - initial release
// ============================================================================
module can_id_hopping_tables #(
    parameter int DEPTH = 8,
    parameter int IDW   = 11,
    parameter int PAGES = 16
) (
    input  logic           clk,
    input  logic           rest_bit,
    input  logic           we,
    input  logic [IDW-1:0] id_i,
    input  logic           send_bit,
    input  logic           receive_bit,
    input  logic [3:0]     rx_tx_message_counter,
    output logic [IDW-1:0] id_o_1,
    output logic [IDW-1:0] id_o_2,
    output logic [7:0]     priority_o,
    output logic           send_hit,
    output logic           recv_hit,
    output logic           cfg_done
);

    localparam int C_TOTAL = DEPTH * (1 + PAGES);
    localparam int C_WPW   = $clog2(C_TOTAL + 1);
    localparam int C_IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Table storage
    logic [IDW-1:0]   r_prio_tab [DEPTH];
    logic [DEPTH-1:0] r_prio_vld;
    logic [IDW-1:0]   r_hop      [PAGES][DEPTH];
    logic [DEPTH-1:0] r_hop_vld  [PAGES];
    logic [C_WPW-1:0] r_wp;
    logic             r_cfg_done;

    // Lookup result registers
    logic [IDW-1:0]   r_id_o_1;
    logic [IDW-1:0]   r_id_o_2;
    logic [7:0]       r_priority;
    logic             r_send_hit;
    logic             r_recv_hit;

    // Search results
    logic [DEPTH-1:0] w_send_match;
    logic [DEPTH-1:0] w_recv_match;
    logic             w_send_found;
    logic             w_recv_found;
    logic [C_IW-1:0]  w_send_idx;
    logic [C_IW-1:0]  w_recv_idx;
    logic             w_send_ok;
    logic             w_recv_ok;
    logic             w_wr_en;

    assign w_wr_en = we && !r_cfg_done;

    // ------------------------------------------------------------------
    // Parallel compare over every slot, then a lowest-index priority
    // encoder so duplicate IDs resolve to the smallest index.
    // ------------------------------------------------------------------
    always_comb begin
        w_send_match = '0;
        w_recv_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_send_match[i] = r_prio_vld[i] && (r_prio_tab[i] == id_i);
            w_recv_match[i] = r_hop_vld[rx_tx_message_counter][i] &&
                              (r_hop[rx_tx_message_counter][i] == id_i);
        end
    end

    always_comb begin
        w_send_found = 1'b0;
        w_recv_found = 1'b0;
        w_send_idx   = '0;
        w_recv_idx   = '0;
        // Descending scan: the last assignment wins, i.e. the lowest index.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_send_match[i]) begin
                w_send_found = 1'b1;
                w_send_idx   = C_IW'(i);
            end
            if (w_recv_match[i]) begin
                w_recv_found = 1'b1;
                w_recv_idx   = C_IW'(i);
            end
        end
    end

    // A priority match only counts if the second-stage entry is also valid.
    assign w_send_ok = w_send_found && r_hop_vld[rx_tx_message_counter][w_send_idx];
    assign w_recv_ok = w_recv_found && r_prio_vld[w_recv_idx];

    // ------------------------------------------------------------------
    // Configuration: one entry per cycle, priority table first, then the
    // hopping table page by page. Write-once until the next reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rest_bit) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_prio_tab[i] <= '0;
            end
            for (int p = 0; p < PAGES; p++) begin
                for (int s = 0; s < DEPTH; s++) begin
                    r_hop[p][s] <= '0;
                end
                r_hop_vld[p] <= '0;
            end
            r_prio_vld <= '0;
            r_wp       <= '0;
            r_cfg_done <= 1'b0;
        end else if (w_wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_wp == C_WPW'(i)) begin
                    r_prio_tab[i] <= id_i;
                    r_prio_vld[i] <= 1'b1;
                end
            end
            for (int p = 0; p < PAGES; p++) begin
                for (int s = 0; s < DEPTH; s++) begin
                    if (r_wp == C_WPW'(DEPTH + p * DEPTH + s)) begin
                        r_hop[p][s]     <= id_i;
                        r_hop_vld[p][s] <= 1'b1;
                    end
                end
            end
            r_wp <= r_wp + C_WPW'(1);
            if (r_wp == C_WPW'(C_TOTAL - 1)) begin
                r_cfg_done <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lookups: a write strobe blocks lookups; send beats receive.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rest_bit) begin
            r_id_o_1   <= '0;
            r_id_o_2   <= '0;
            r_priority <= '0;
            r_send_hit <= 1'b0;
            r_recv_hit <= 1'b0;
        end else if (!we) begin
            if (send_bit) begin
                r_send_hit <= w_send_ok;
                if (w_send_ok) begin
                    r_id_o_1   <= r_hop[rx_tx_message_counter][w_send_idx];
                    r_priority <= 8'(w_send_idx);
                end
            end else if (receive_bit) begin
                r_recv_hit <= w_recv_ok;
                if (w_recv_ok) begin
                    r_id_o_2   <= r_prio_tab[w_recv_idx];
                    r_priority <= 8'(w_recv_idx);
                end
            end
        end
    end

    assign id_o_1     = r_id_o_1;
    assign id_o_2     = r_id_o_2;
    assign priority_o = r_priority;
    assign send_hit   = r_send_hit;
    assign recv_hit   = r_recv_hit;
    assign cfg_done   = r_cfg_done;

endmodule
`default_nettype wire

// File: tb/tb_can_id_hopping_tables.sv
`default_nettype none
// ============================================================================
//  Module      : tb_can_id_hopping_tables
//  Description : Self-checking bench for can_id_hopping_tables. Directed
//                scenarios followed by randomized traffic compared against a
//                table-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_can_id_hopping_tables;

    localparam int DEPTH = 8;
    localparam int IDW   = 11;
    localparam int PAGES = 16;
    localparam int TOTAL = DEPTH * (1 + PAGES);

    logic           clk = 1'b0;
    logic           rest_bit = 1'b1;
    logic           we = 1'b0;
    logic [IDW-1:0] id_i = '0;
    logic           send_bit = 1'b0;
    logic           receive_bit = 1'b0;
    logic [3:0]     rx_tx_message_counter = '0;
    logic [IDW-1:0] id_o_1;
    logic [IDW-1:0] id_o_2;
    logic [7:0]     priority_o;
    logic           send_hit;
    logic           recv_hit;
    logic           cfg_done;

    always #5 clk = ~clk;

    can_id_hopping_tables #(.DEPTH(DEPTH), .IDW(IDW), .PAGES(PAGES)) u_dut (
        .clk                   (clk),
        .rest_bit              (rest_bit),
        .we                    (we),
        .id_i                  (id_i),
        .send_bit              (send_bit),
        .receive_bit           (receive_bit),
        .rx_tx_message_counter (rx_tx_message_counter),
        .id_o_1                (id_o_1),
        .id_o_2                (id_o_2),
        .priority_o            (priority_o),
        .send_hit              (send_hit),
        .recv_hit              (recv_hit),
        .cfg_done              (cfg_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  m_prio [DEPTH];
    bit  m_pv   [DEPTH];
    int  m_hop  [PAGES][DEPTH];
    bit  m_hv   [PAGES][DEPTH];
    int  m_wp;
    bit  m_done;
    int  m_id1, m_id2, m_pri;
    bit  m_sh, m_rh;

    task automatic model_step(input bit rst, input bit w, input int id,
                              input bit s, input bit r, input int pg);
        int  slot;
        bit  found;
        if (rst) begin
            foreach (m_prio[i]) begin m_prio[i] = 0; m_pv[i] = 0; end
            foreach (m_hop[p, q]) begin m_hop[p][q] = 0; m_hv[p][q] = 0; end
            m_wp = 0; m_done = 0;
            m_id1 = 0; m_id2 = 0; m_pri = 0; m_sh = 0; m_rh = 0;
        end else if (w) begin
            if (!m_done) begin
                if (m_wp < DEPTH) begin
                    m_prio[m_wp] = id; m_pv[m_wp] = 1;
                end else begin
                    m_hop[(m_wp - DEPTH) / DEPTH][(m_wp - DEPTH) % DEPTH] = id;
                    m_hv [(m_wp - DEPTH) / DEPTH][(m_wp - DEPTH) % DEPTH] = 1;
                end
                m_wp++;
                if (m_wp == TOTAL) m_done = 1;
            end
        end else if (s) begin
            found = 0; slot = 0;
            for (int i = 0; i < DEPTH && !found; i++)
                if (m_pv[i] && m_prio[i] == id) begin found = 1; slot = i; end
            if (found && m_hv[pg][slot]) begin
                m_id1 = m_hop[pg][slot]; m_pri = slot; m_sh = 1;
            end else begin
                m_sh = 0;
            end
        end else if (r) begin
            found = 0; slot = 0;
            for (int i = 0; i < DEPTH && !found; i++)
                if (m_hv[pg][i] && m_hop[pg][i] == id) begin found = 1; slot = i; end
            if (found && m_pv[slot]) begin
                m_id2 = m_prio[slot]; m_pri = slot; m_rh = 1;
            end else begin
                m_rh = 0;
            end
        end
    endtask

    // Drive one cycle, advance the model, then compare all outputs.
    task automatic step(input bit rst, input bit w, input int id,
                        input bit s, input bit r, input int pg);
        rest_bit = rst; we = w; id_i = IDW'(id);
        send_bit = s; receive_bit = r; rx_tx_message_counter = 4'(pg);
        @(posedge clk);
        model_step(rst, w, id, s, r, pg);
        #1;
        check_eq("id_o_1",     32'(id_o_1),     32'(m_id1));
        check_eq("id_o_2",     32'(id_o_2),     32'(m_id2));
        check_eq("priority_o", 32'(priority_o), 32'(m_pri));
        check_eq("send_hit",   32'(send_hit),   32'(m_sh));
        check_eq("recv_hit",   32'(recv_hit),   32'(m_rh));
        check_eq("cfg_done",   32'(cfg_done),   32'(m_done));
    endtask

    task automatic rand_id(output int id);
        if ($urandom_range(0, 3) == 0) id = int'($urandom_range(0, 2047));
        else                           id = int'($urandom_range(0, 15));
    endtask

    initial begin
        int op, id, cyc;

        // ---- reset ----
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 'h103, 1, 1, 2);
        check_eq("rst_id_o_1", 32'(id_o_1), 32'h0);
        check_eq("rst_prio",   32'(priority_o), 32'h0);
        check_eq("rst_done",   32'(cfg_done), 32'h0);

        // ---- configure all 136 entries ----
        for (int n = 0; n < TOTAL; n++) begin
            if (n < DEPTH) step(0, 1, 'h100 + n, 0, 0, 0);
            else           step(0, 1, 'h400 + 16 * ((n - DEPTH) / DEPTH) + (n - DEPTH) % DEPTH, 0, 0, 0);
            if (n == TOTAL - 2) check_eq("done_after_135", 32'(cfg_done), 32'h0);
        end
        check_eq("done_after_136", 32'(cfg_done), 32'h1);

        // 137th write must be ignored
        step(0, 1, 'h7FF, 0, 0, 0);
        step(0, 0, 'h4F7, 0, 1, 15);
        check_eq("hop15_7_kept", 32'(id_o_2), 32'h107);
        check_eq("hop15_7_hit",  32'(recv_hit), 32'h1);

        step(0, 0, 'h103, 1, 0, 2);
        check_eq("send_id",   32'(id_o_1), 32'h423);
        check_eq("send_prio", 32'(priority_o), 32'h3);
        check_eq("send_hit",  32'(send_hit), 32'h1);

        step(0, 0, 'h1FF, 1, 0, 2);
        check_eq("send_miss",      32'(send_hit), 32'h0);
        check_eq("send_miss_hold", 32'(id_o_1), 32'h423);

        step(0, 0, 'h425, 0, 1, 2);
        check_eq("recv_id",   32'(id_o_2), 32'h105);
        check_eq("recv_prio", 32'(priority_o), 32'h5);
        check_eq("recv_hit",  32'(recv_hit), 32'h1);

        step(0, 0, 'h425, 0, 1, 3);
        check_eq("recv_miss",      32'(recv_hit), 32'h0);
        check_eq("recv_miss_hold", 32'(id_o_2), 32'h105);

        step(0, 0, 'h101, 1, 1, 0);
        check_eq("both_id1",  32'(id_o_1), 32'h401);
        check_eq("both_hit",  32'(send_hit), 32'h1);
        check_eq("both_id2",  32'(id_o_2), 32'h105);

        step(0, 1, 'h102, 1, 0, 0);
        check_eq("we_blocks_id1",  32'(id_o_1), 32'h401);
        check_eq("we_blocks_prio", 32'(priority_o), 32'h1);

        // ---- reset mid-configuration ----
        step(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 20; n++) step(0, 1, 'h100 + n, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check_eq("midrst_id1",  32'(id_o_1), 32'h0);
        check_eq("midrst_hit",  32'(send_hit), 32'h0);
        step(0, 0, 'h100, 1, 0, 0);
        check_eq("midrst_send_miss", 32'(send_hit), 32'h0);

        // ---- rewrite with new data ----
        for (int n = 0; n < TOTAL; n++) begin
            if (n < DEPTH) step(0, 1, 'h200 + n, 0, 0, 0);
            else           step(0, 1, 'h600 + 16 * ((n - DEPTH) / DEPTH) + (n - DEPTH) % DEPTH, 0, 0, 0);
        end
        step(0, 0, 'h203, 1, 0, 5);
        check_eq("rewrite_id1", 32'(id_o_1), 32'h653);
        check_eq("rewrite_hit", 32'(send_hit), 32'h1);

        // ---- randomized traffic ----
        for (int round = 0; round < 6; round++) begin
            step(1, 0, 0, 0, 0, 0);
            for (cyc = 0; cyc < 400; cyc++) begin
                op = int'($urandom_range(0, 9));
                rand_id(id);
                if ($urandom_range(0, 199) == 0)
                    step(1, 0, id, 0, 0, 0);
                else if (op <= 3)
                    step(0, 1, id, $urandom_range(0, 1) == 1, 0, int'($urandom_range(0, 15)));
                else if (op <= 6)
                    step(0, 0, id, 1, $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)));
                else if (op <= 8)
                    step(0, 0, id, 0, 1, int'($urandom_range(0, 15)));
                else
                    step(0, 0, id, 0, 0, int'($urandom_range(0, 15)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
